// File: rtl/pulse_transmitter_pkg.sv
// Shared widths and helpers for the pulse transmitter symbol path.
package pulse_transmitter_pkg;

  localparam int unsigned SYM_W         = 2;
  localparam int unsigned SYMS_PER_WORD = 16;
  localparam int unsigned WORD_W        = 32;
  localparam int unsigned IDX_W         = $clog2(SYMS_PER_WORD);
  localparam int unsigned BSEL_W        = $clog2(WORD_W);

  // Width needed to express 0..depth*SYMS_PER_WORD buffered symbols.
  function automatic int unsigned sym_level_width(input int unsigned depth);
    return $clog2(depth * SYMS_PER_WORD + 1);
  endfunction

endpackage

// File: rtl/pulse_transmitter_symbol_feeder_if.sv
// CPU write path and transmitter fetch path of the symbol feeder.
interface pulse_transmitter_symbol_feeder_if
  import pulse_transmitter_pkg::*;
#(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned LEVEL_W = sym_level_width(DEPTH);

  logic [WORD_W-1:0]  wr_data;
  logic               wr_valid;
  logic               wr_ready;
  logic               flush;
  logic               sym_req;
  logic [SYM_W-1:0]   sym_data;
  logic               sym_valid;
  logic [LEVEL_W-1:0] level;
  logic               low_water_irq;
  logic               underflow;
  logic               underflow_clr;

  modport master (
    output wr_data, wr_valid, flush, sym_req, underflow_clr,
    input  wr_ready, sym_data, sym_valid, level, low_water_irq, underflow
  );

  modport slave (
    input  wr_data, wr_valid, flush, sym_req, underflow_clr,
    output wr_ready, sym_data, sym_valid, level, low_water_irq, underflow
  );

endinterface

// File: rtl/pulse_transmitter_sync_fifo.sv
// Plain synchronous word FIFO with combinational head output and clear.
module pulse_transmitter_sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_cnt;
  logic             w_push;
  logic             w_pop;

  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

  // Pointers wrap naturally; DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign dout  = r_mem[r_rd_ptr];
  assign count = r_cnt;
  assign full  = (r_cnt == CNT_W'(DEPTH));
  assign empty = (r_cnt == CNT_W'(0));

endmodule

// File: rtl/pulse_transmitter_symbol_feeder.sv
// Buffers 32-bit symbol words and unpacks them LSB-first into 2-bit symbols on request.
module pulse_transmitter_symbol_feeder
  import pulse_transmitter_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned LOW_WATER = 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  pulse_transmitter_symbol_feeder_if.slave     bus
);
  localparam int unsigned CNT_W   = $clog2(DEPTH+1);
  localparam int unsigned LEVEL_W = sym_level_width(DEPTH);

  logic [WORD_W-1:0] w_head;
  logic [CNT_W-1:0]  w_cnt;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_fire;
  logic              w_pop;
  logic [BSEL_W-1:0] w_bit_sel;
  logic [IDX_W-1:0]  r_sym_idx;
  logic              r_underflow;

  // Flush takes priority over both the write and the fetch in the same cycle.
  assign w_push    = bus.wr_valid & ~w_full & ~bus.flush;
  assign w_fire    = bus.sym_req & ~w_empty & ~bus.flush;
  assign w_pop     = w_fire & (r_sym_idx == IDX_W'(SYMS_PER_WORD-1));
  assign w_bit_sel = BSEL_W'(r_sym_idx) * BSEL_W'(SYM_W);

  pulse_transmitter_sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (bus.flush),
    .push  (w_push),
    .pop   (w_pop),
    .din   (bus.wr_data),
    .dout  (w_head),
    .count (w_cnt),
    .full  (w_full),
    .empty (w_empty)
  );

  // Symbol index wraps to 0 exactly when the head word pops.
  always_ff @(posedge clk) begin
    if (rst || bus.flush) r_sym_idx <= '0;
    else if (w_fire)      r_sym_idx <= r_sym_idx + IDX_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst)                                         r_underflow <= 1'b0;
    else if (bus.sym_req && w_empty && !bus.flush)   r_underflow <= 1'b1;
    else if (bus.underflow_clr)                      r_underflow <= 1'b0;
  end

  assign bus.wr_ready      = ~w_full;
  assign bus.sym_valid     = ~w_empty;
  assign bus.sym_data      = w_empty ? SYM_W'(0) : w_head[w_bit_sel +: SYM_W];
  assign bus.level         = LEVEL_W'(w_cnt) * LEVEL_W'(SYMS_PER_WORD) - LEVEL_W'(r_sym_idx);
  assign bus.low_water_irq = (w_cnt <= CNT_W'(LOW_WATER));
  assign bus.underflow     = r_underflow;

endmodule

// File: tb/tb_pulse_transmitter_symbol_feeder.sv
// Directed bench for the symbol feeder: unpack order, full/drop, underflow, collision, flush, reset.
module tb_pulse_transmitter_symbol_feeder;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  pulse_transmitter_symbol_feeder_if #(.DEPTH(4)) bus ();

  pulse_transmitter_symbol_feeder #(
    .DEPTH     (4),
    .LOW_WATER (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic write_word(input logic [31:0] d);
    bus.wr_data  = d;
    bus.wr_valid = 1'b1;
    step();
    bus.wr_valid = 1'b0;
  endtask

  task automatic req(input int n);
    for (int k = 0; k < n; k++) begin
      bus.sym_req = 1'b1;
      step();
      bus.sym_req = 1'b0;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_wr_ready"},  32'(bus.wr_ready),      32'd1);
    chk({tag, "_sym_valid"}, 32'(bus.sym_valid),     32'd0);
    chk({tag, "_sym_data"},  32'(bus.sym_data),      32'd0);
    chk({tag, "_level"},     32'(bus.level),         32'd0);
    chk({tag, "_low_water"}, 32'(bus.low_water_irq), 32'd1);
    chk({tag, "_underflow"}, 32'(bus.underflow),     32'd0);
  endtask

  initial begin
    rst               = 1'b1;
    bus.wr_data       = '0;
    bus.wr_valid      = 1'b0;
    bus.flush         = 1'b0;
    bus.sym_req       = 1'b0;
    bus.underflow_clr = 1'b0;
    step();
    rst = 1'b0;
    chk_reset_vals("por");

    // 1: 0xE4 repeated unpacks as 0,1,2,3 LSB-first
    write_word(32'hE4E4E4E4);
    chk("t1_valid", 32'(bus.sym_valid), 32'd1);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("t1_sym%0d", i), 32'(bus.sym_data), 32'(i % 4));
      chk($sformatf("t1_lvl%0d", i), 32'(bus.level), 32'(16 - i));
      req(1);
      step();
    end
    chk("t1_valid_end", 32'(bus.sym_valid), 32'd0);
    chk("t1_level_end", 32'(bus.level), 32'd0);

    // 2: fill to full, extra write dropped
    write_word(32'hFFFFFFFF);
    write_word(32'h55555555);
    write_word(32'hAAAAAAAA);
    chk("t2_ready_3", 32'(bus.wr_ready), 32'd1);
    write_word(32'h00000000);
    chk("t2_ready_full", 32'(bus.wr_ready), 32'd0);
    chk("t2_level_full", 32'(bus.level), 32'd64);
    chk("t2_lowwater_full", 32'(bus.low_water_irq), 32'd0);
    write_word(32'hDEADBEEF);
    chk("t2_level_drop", 32'(bus.level), 32'd64);
    chk("t2_head_w0", 32'(bus.sym_data), 32'd3);
    req(16);
    chk("t2_ready_after", 32'(bus.wr_ready), 32'd1);
    chk("t2_level_after", 32'(bus.level), 32'd48);
    chk("t2_head_w1", 32'(bus.sym_data), 32'd1);
    req(16);
    chk("t2_head_w2", 32'(bus.sym_data), 32'd2);
    chk("t2_lowwater_2", 32'(bus.low_water_irq), 32'd0);
    req(16);
    chk("t2_head_w3", 32'(bus.sym_data), 32'd0);
    chk("t2_lowwater_1", 32'(bus.low_water_irq), 32'd1);
    req(16);
    chk("t2_drained", 32'(bus.sym_valid), 32'd0);
    chk("t2_drained_lvl", 32'(bus.level), 32'd0);

    // 3: underflow set/clear priority
    req(1);
    chk("t3_uf_set", 32'(bus.underflow), 32'd1);
    chk("t3_uf_level", 32'(bus.level), 32'd0);
    bus.underflow_clr = 1'b1;
    req(1);
    chk("t3_uf_setwins", 32'(bus.underflow), 32'd1);
    step();
    bus.underflow_clr = 1'b0;
    chk("t3_uf_clr", 32'(bus.underflow), 32'd0);

    // 4: push and pop collide on the last symbol of the head word
    write_word(32'hC0000000);
    write_word(32'h00000002);
    req(15);
    chk("t4_level_pre", 32'(bus.level), 32'd17);
    chk("t4_sym15", 32'(bus.sym_data), 32'd3);
    bus.wr_data  = 32'h00000001;
    bus.wr_valid = 1'b1;
    bus.sym_req  = 1'b1;
    step();
    bus.wr_valid = 1'b0;
    bus.sym_req  = 1'b0;
    chk("t4_level_post", 32'(bus.level), 32'd32);
    chk("t4_head_b", 32'(bus.sym_data), 32'd2);
    req(16);
    chk("t4_head_c", 32'(bus.sym_data), 32'd1);
    chk("t4_level_c", 32'(bus.level), 32'd16);
    req(16);
    chk("t4_drained", 32'(bus.sym_valid), 32'd0);

    // 5: flush beats concurrent write and fetch
    write_word(32'h11111111);
    write_word(32'h11111111);
    write_word(32'h11111111);
    req(5);
    chk("t5_level_pre", 32'(bus.level), 32'd43);
    bus.flush    = 1'b1;
    bus.wr_data  = 32'h12345678;
    bus.wr_valid = 1'b1;
    bus.sym_req  = 1'b1;
    step();
    bus.flush    = 1'b0;
    bus.wr_valid = 1'b0;
    bus.sym_req  = 1'b0;
    chk("t5_level", 32'(bus.level), 32'd0);
    chk("t5_valid", 32'(bus.sym_valid), 32'd0);
    chk("t5_lowwater", 32'(bus.low_water_irq), 32'd1);
    chk("t5_uf", 32'(bus.underflow), 32'd0);
    step();
    chk("t5_write_dropped", 32'(bus.level), 32'd0);

    // 6: mid-stream reset
    req(1);
    write_word(32'hFFFFFFFF);
    write_word(32'hFFFFFFFF);
    write_word(32'hFFFFFFFF);
    write_word(32'hFFFFFFFF);
    req(7);
    chk("t6_level_pre", 32'(bus.level), 32'd57);
    chk("t6_uf_pre", 32'(bus.underflow), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_reset_vals("t6");
    write_word(32'h00000001);
    chk("t6_sym_after", 32'(bus.sym_data), 32'd1);
    chk("t6_level_after", 32'(bus.level), 32'd16);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
